// File: rtl/tau_microcode_pkg.sv
// Shared types and default geometry for the microcode sequencer slice.
package tau_microcode_pkg;

   localparam int TAU_OPCODE_WIDTH = 6;
   localparam int TAU_STEP_WIDTH   = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOADED   = 3'd1,
      STEPPING = 3'd2,
      DONE     = 3'd3,
      FAULT    = 3'd4
   } microcode_seq_state_t;

   typedef struct packed {
      logic [TAU_OPCODE_WIDTH-1:0] opcode;
      logic [TAU_STEP_WIDTH-1:0]   step;
   } microcode_address_t;

endpackage

// File: rtl/microcode_step_counter.sv
// Micro-step counter: synchronous clear (priority), count enable, terminal-count flag.
module microcode_step_counter
   import tau_microcode_pkg::*;
#(
   parameter int STEP_WIDTH = TAU_STEP_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  clr_i,
   input  logic                  en_i,
   output logic [STEP_WIDTH-1:0] count_o,
   output logic                  tc_o
);

   logic [STEP_WIDTH-1:0] count_q;
   logic [STEP_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (en_i)
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o = count_q;
   assign tc_o    = &count_q;

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: latches opcode, steps micro-step counter, retires on ROM finish bit.
// Optional step-overflow trap (FAULT state, sticky fault) built with TAU_MICROCODE_OVERFLOW_TRAP_EN.
module microcode_sequencer
   import tau_microcode_pkg::*;
#(
   parameter int OPCODE_WIDTH       = TAU_OPCODE_WIDTH,
   parameter int STEP_WIDTH         = TAU_STEP_WIDTH,
   parameter int RETIRE_COUNT_WIDTH = 16
) (
   input  logic                               clock,
   input  logic                               reset_n,
   input  logic                               microcode_sequencer_load_n,
   input  logic                               microcode_sequencer_enable,
   input  logic                               microcode_rom_read_enable,
   input  logic [OPCODE_WIDTH-1:0]            opcode,
   input  logic                               instruction_finish_control_line,
   output logic [OPCODE_WIDTH+STEP_WIDTH-1:0] microcode_address,
   output logic                               microcode_address_valid,
   output logic                               instruction_retired,
   output logic [RETIRE_COUNT_WIDTH-1:0]      retired_count,
   output logic                               microcode_fault
);

   // Assert asynchronously, release two clocks after reset_n rises.
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         rst_sync_q <= 2'b00;
      else
         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n_int = rst_sync_q[1];

   microcode_seq_state_t          state_q;
   logic [OPCODE_WIDTH-1:0]       opcode_q;
   logic [STEP_WIDTH-1:0]         step_q;
   logic                          retired_q;
   logic [RETIRE_COUNT_WIDTH-1:0] retired_count_q;
   logic                          step_tc;
   logic                          live;
   logic                          load_accept;
   logic                          finish_hit;
   logic                          step_req;
   logic                          overflow;
   logic                          step_en;

   assign live        = (state_q == LOADED) || (state_q == STEPPING);
   assign load_accept = !microcode_sequencer_load_n && (state_q != FAULT);
   assign finish_hit  = live && instruction_finish_control_line && microcode_rom_read_enable;
   assign step_req    = live && microcode_sequencer_enable && !instruction_finish_control_line;

`ifdef TAU_MICROCODE_OVERFLOW_TRAP_EN
   logic fault_q;

   assign overflow = step_req && step_tc;
`else
   logic unused_step_tc;

   // Without the trap the counter simply wraps past all-ones.
   assign unused_step_tc = step_tc;
   assign overflow       = 1'b0;
`endif

   assign step_en = !load_accept && step_req && !overflow;

   microcode_step_counter #(
      .STEP_WIDTH (STEP_WIDTH)
   ) u_step_counter (
      .clk_i   (clock),
      .rst_n_i (rst_n_int),
      .clr_i   (load_accept),
      .en_i    (step_en),
      .count_o (step_q),
      .tc_o    (step_tc)
   );

   // Priority: load, then finish, then overflow, then step.
   always_ff @(posedge clock or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q         <= IDLE;
         opcode_q        <= '0;
         retired_q       <= 1'b0;
         retired_count_q <= '0;
`ifdef TAU_MICROCODE_OVERFLOW_TRAP_EN
         fault_q         <= 1'b0;
`endif
      end else begin
         retired_q <= 1'b0;
         if (load_accept) begin
            state_q  <= LOADED;
            opcode_q <= opcode;
         end else if (finish_hit) begin
            state_q         <= DONE;
            retired_q       <= 1'b1;
            retired_count_q <= retired_count_q + 1'b1;
         end else if (overflow) begin
`ifdef TAU_MICROCODE_OVERFLOW_TRAP_EN
            state_q <= FAULT;
            fault_q <= 1'b1;
`endif
         end else if (step_req) begin
            state_q <= STEPPING;
         end
      end
   end

   assign microcode_address       = {opcode_q, step_q};
   assign microcode_address_valid = microcode_rom_read_enable &&
                                    (state_q inside {LOADED, STEPPING, DONE});
   assign instruction_retired     = retired_q;
   assign retired_count           = retired_count_q;

`ifdef TAU_MICROCODE_OVERFLOW_TRAP_EN
   assign microcode_fault = fault_q;
`else
   assign microcode_fault = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: directed stimulus pushes expectations, a monitor compares.
// The retire counter is instantiated narrow (8 bits) so its wrap is reached in a few hundred cycles.
module tb_microcode_sequencer;
   import tau_microcode_pkg::*;

   localparam int OW  = 6;
   localparam int SW  = 4;
   localparam int RCW = 8;

   logic           clock = 1'b0;
   logic           reset_n;
   logic           load_n;
   logic           en;
   logic           rd;
   logic           fin;
   logic [OW-1:0]  op;
   logic [OW+SW-1:0] microcode_address;
   logic           microcode_address_valid;
   logic           instruction_retired;
   logic [RCW-1:0] retired_count;
   logic           microcode_fault;

   typedef struct {
      string          name;
      logic [9:0]     addr;
      logic           valid;
      logic           fault;
      logic [RCW-1:0] cnt;
   } obs_t;

   typedef struct {
      logic [9:0]     addr;
      logic [RCW-1:0] cnt;
   } ret_t;

   obs_t obs_q[$];
   ret_t ret_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   event chk_now;

   always #5 clock = ~clock;

   microcode_sequencer #(
      .OPCODE_WIDTH       (OW),
      .STEP_WIDTH         (SW),
      .RETIRE_COUNT_WIDTH (RCW)
   ) dut (
      .clock                           (clock),
      .reset_n                         (reset_n),
      .microcode_sequencer_load_n      (load_n),
      .microcode_sequencer_enable      (en),
      .microcode_rom_read_enable       (rd),
      .opcode                          (op),
      .instruction_finish_control_line (fin),
      .microcode_address               (microcode_address),
      .microcode_address_valid         (microcode_address_valid),
      .instruction_retired             (instruction_retired),
      .retired_count                   (retired_count),
      .microcode_fault                 (microcode_fault)
   );

   function automatic logic [9:0] mk(input logic [5:0] o, input logic [3:0] s);
      microcode_address_t a;
      a.opcode = o;
      a.step   = s;
      return a;
   endfunction

   task automatic expect_obs(input string nm, input logic [9:0] a, input logic v,
                             input logic f, input logic [RCW-1:0] c);
      obs_t e;
      e.name  = nm;
      e.addr  = a;
      e.valid = v;
      e.fault = f;
      e.cnt   = c;
      obs_q.push_back(e);
   endtask

   task automatic expect_ret(input logic [9:0] a, input logic [RCW-1:0] c);
      ret_t r;
      r.addr = a;
      r.cnt  = c;
      ret_q.push_back(r);
   endtask

   // Drive one cycle of driver controls on the negedge; DUT samples on the next posedge.
   task automatic cyc(input logic ln, input logic e, input logic r, input logic f,
                      input logic [5:0] o);
      load_n = ln;
      en     = e;
      rd     = r;
      fin    = f;
      op     = o;
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      load_n  = 1'b1;
      en      = 1'b0;
      rd      = 1'b0;
      fin     = 1'b0;
      op      = '0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
   endtask

   // Monitor: compares queued observations and every retire pulse shortly after each posedge.
   initial begin
      forever begin
         @(posedge clock or chk_now);
         #2;
         while (obs_q.size() > 0) begin
            obs_t e;
            e = obs_q.pop_front();
            n_tests++;
            if (microcode_address !== e.addr || microcode_address_valid !== e.valid ||
                microcode_fault !== e.fault || retired_count !== e.cnt) begin
               n_fail++;
               $display("FAIL %s: got addr=%h valid=%b fault=%b count=%0d, want addr=%h valid=%b fault=%b count=%0d",
                        e.name, microcode_address, microcode_address_valid, microcode_fault,
                        retired_count, e.addr, e.valid, e.fault, e.cnt);
            end
         end
         if (instruction_retired !== 1'b0) begin
            n_tests++;
            if (ret_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_retire: got retired=%b at addr=%h, want retired=0",
                        instruction_retired, microcode_address);
            end else begin
               ret_t r;
               r = ret_q.pop_front();
               if (instruction_retired !== 1'b1 || microcode_address !== r.addr ||
                   retired_count !== r.cnt) begin
                  n_fail++;
                  $display("FAIL retire: got retired=%b addr=%h count=%0d, want retired=1 addr=%h count=%0d",
                           instruction_retired, microcode_address, retired_count, r.addr, r.cnt);
               end
            end
         end
      end
   end

   initial begin
      logic [RCW-1:0] cnt;
      logic [5:0]     o;

      do_reset();

      // Reset state; IDLE ignores read enable, step and finish.
      expect_obs("reset_idle", 10'h000, 1'b0, 1'b0, 8'd0);
      cyc(1, 0, 1, 0, 6'h00);
      expect_obs("idle_ignores", 10'h000, 1'b0, 1'b0, 8'd0);
      cyc(1, 1, 1, 1, 6'h3F);

      // One-cycle opcode retires at step 0.
      expect_obs("one_cycle_load", 10'h050, 1'b0, 1'b0, 8'd0);
      cyc(0, 0, 0, 0, 6'h05);
      expect_obs("one_cycle_retire", 10'h050, 1'b1, 1'b0, 8'd1);
      expect_ret(10'h050, 8'd1);
      cyc(1, 0, 1, 1, 6'h05);
      expect_obs("done_ignores_finish", 10'h050, 1'b1, 1'b0, 8'd1);
      cyc(1, 1, 1, 1, 6'h05);

      // Multi-step opcode.
      expect_obs("multi_load", 10'h2A0, 1'b1, 1'b0, 8'd1);
      cyc(0, 0, 1, 0, 6'h2A);
      expect_obs("multi_step1", 10'h2A1, 1'b1, 1'b0, 8'd1);
      cyc(1, 1, 1, 0, 6'h2A);
      expect_obs("multi_step2", 10'h2A2, 1'b1, 1'b0, 8'd1);
      cyc(1, 1, 1, 0, 6'h2A);
      expect_obs("multi_step3", 10'h2A3, 1'b1, 1'b0, 8'd1);
      cyc(1, 1, 1, 0, 6'h2A);
      expect_obs("multi_retire", 10'h2A3, 1'b1, 1'b0, 8'd2);
      expect_ret(10'h2A3, 8'd2);
      cyc(1, 0, 1, 1, 6'h2A);
      expect_obs("done_ignores_enable", 10'h2A3, 1'b1, 1'b0, 8'd2);
      cyc(1, 1, 1, 0, 6'h2A);
      expect_obs("done_rd_low", 10'h2A3, 1'b0, 1'b0, 8'd2);
      cyc(1, 0, 0, 0, 6'h2A);

      // Load beats enable and finish.
      expect_obs("load_11", 10'h110, 1'b1, 1'b0, 8'd2);
      cyc(0, 0, 1, 0, 6'h11);
      for (int i = 1; i <= 7; i++) begin
         expect_obs("walk_to_7", mk(6'h11, 4'(i)), 1'b1, 1'b0, 8'd2);
         cyc(1, 1, 1, 0, 6'h11);
      end
      expect_obs("hold_at_7", 10'h117, 1'b1, 1'b0, 8'd2);
      cyc(1, 0, 1, 0, 6'h11);
      expect_obs("load_over_enable", 10'h3F0, 1'b1, 1'b0, 8'd2);
      cyc(0, 1, 1, 0, 6'h3F);
      expect_obs("step_after_reload", 10'h3F1, 1'b1, 1'b0, 8'd2);
      cyc(1, 1, 1, 0, 6'h3F);
      expect_obs("load_over_finish", 10'h0C0, 1'b1, 1'b0, 8'd2);
      cyc(0, 1, 1, 1, 6'h0C);

      // Asynchronous reset mid-step at step 3.
      expect_obs("load_2B", 10'h2B0, 1'b1, 1'b0, 8'd2);
      cyc(0, 0, 1, 0, 6'h2B);
      for (int i = 1; i <= 3; i++) begin
         expect_obs("step_2B", mk(6'h2B, 4'(i)), 1'b1, 1'b0, 8'd2);
         cyc(1, 1, 1, 0, 6'h2B);
      end
      #1;
      reset_n = 1'b0;
      expect_obs("async_reset", 10'h000, 1'b0, 1'b0, 8'd0);
      -> chk_now;
      #3;
      do_reset();

      // Step overflow after 16 consecutive enables.
      expect_obs("ovf_load", 10'h010, 1'b1, 1'b0, 8'd0);
      cyc(0, 0, 1, 0, 6'h01);
      for (int i = 1; i <= 15; i++) begin
         expect_obs("ovf_walk", mk(6'h01, 4'(i)), 1'b1, 1'b0, 8'd0);
         cyc(1, 1, 1, 0, 6'h01);
      end
`ifdef TAU_MICROCODE_OVERFLOW_TRAP_EN
      expect_obs("ovf_trap", 10'h01F, 1'b0, 1'b1, 8'd0);
      cyc(1, 1, 1, 0, 6'h01);
      expect_obs("fault_ignores_load", 10'h01F, 1'b0, 1'b1, 8'd0);
      cyc(0, 0, 1, 0, 6'h22);
      expect_obs("fault_sticky", 10'h01F, 1'b0, 1'b1, 8'd0);
      cyc(1, 0, 1, 1, 6'h22);
`else
      expect_obs("ovf_wrap", 10'h010, 1'b1, 1'b0, 8'd0);
      cyc(1, 1, 1, 0, 6'h01);
      expect_obs("step_after_wrap", 10'h011, 1'b1, 1'b0, 8'd0);
      cyc(1, 1, 1, 0, 6'h01);
      expect_obs("reload_after_wrap", 10'h220, 1'b1, 1'b0, 8'd0);
      cyc(0, 0, 1, 0, 6'h22);
`endif
      do_reset();

      // Retire counter wraps modulo 2^RCW; each retirement must give exactly one pulse.
      cnt = '0;
      for (int i = 0; i < (1 << RCW); i++) begin
         o = 6'(i);
         cyc(0, 0, 1, 0, o);
         cnt = cnt + 1'b1;
         expect_ret(mk(o, 4'h0), cnt);
         if (i >= (1 << RCW) - 2)
            expect_obs("wrap_retire", mk(o, 4'h0), 1'b1, 1'b0, cnt);
         cyc(1, 0, 1, 1, o);
      end
      expect_obs("wrap_done_zero", 10'h3F0, 1'b1, 1'b0, 8'd0);
      cyc(1, 0, 1, 0, 6'h00);
      cyc(0, 0, 1, 0, 6'h07);
      expect_obs("retire_after_wrap", 10'h070, 1'b1, 1'b0, 8'd1);
      expect_ret(10'h070, 8'd1);
      cyc(1, 0, 1, 1, 6'h07);

      cyc(1, 0, 0, 0, 6'h00);
      repeat (3) @(negedge clock);
      n_tests++;
      if (ret_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_retire: got %0d pulses outstanding, want 0", ret_q.size());
      end
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL obs_pending: got %0d checks outstanding, want 0", obs_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
